// File: rtl/mac_dot_sat.sv
// Multi-lane signed dot-product MAC with per-step saturating accumulation and sticky clip flags.
// Two-stage pipeline (lane product sum, then accumulate); emits one result per LEN accepted samples.
module mac_dot_sat #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int LANES = 1,
  parameter int ACC_W = 26,
  parameter int LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_n,
  input  logic                    in_vld,
  input  logic [LANES*A_W-1:0]    a,
  input  logic [LANES*B_W-1:0]    b,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic signed [ACC_W-1:0] res,
  output logic                    res_vld,
  output logic                    res_sat_hi,
  output logic                    res_sat_lo
);

  localparam int PR_W  = A_W + B_W;
  localparam int P_W   = PR_W + $clog2(LANES);
  localparam int S_W   = ACC_W + 1;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int LAST  = (LEN > 0) ? LEN - 1 : 0;

  localparam logic signed [ACC_W:0]   MAX_S = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   MIN_S = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_A = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1: lane product sum
  logic signed [P_W-1:0]  p_d, p_q;
  logic                   p_vld_d, p_vld_q;
  logic signed [A_W-1:0]  a_l;
  logic signed [B_W-1:0]  b_l;
  logic signed [PR_W-1:0] prod;

  always_comb begin
    p_d  = '0;
    a_l  = '0;
    b_l  = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l  = a[i*A_W +: A_W];
      b_l  = b[i*B_W +: B_W];
      prod = PR_W'(a_l) * PR_W'(b_l);
      p_d  = p_d + P_W'(prod);
    end
    p_vld_d = in_vld;
  end

  // Stage 2: accumulate with clipping; first term of a frame starts from zero
  logic signed [ACC_W-1:0] acc_d, acc_q, res_d, res_q, base, sat_v;
  logic signed [ACC_W:0]   s;
  logic                    sat_hi_d, sat_hi_q, sat_lo_d, sat_lo_q;
  logic                    res_vld_d, res_vld_q, res_hi_d, res_hi_q, res_lo_d, res_lo_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    first, hi, lo;

  always_comb begin
    first = (LEN > 0) && (cnt_q == '0);
    base  = first ? '0 : acc_q;
    s     = S_W'(base) + S_W'(p_q);
    hi    = (s > MAX_S);
    lo    = (s < MIN_S);
    sat_v = hi ? MAX_A : (lo ? MIN_A : s[ACC_W-1:0]);

    acc_d     = acc_q;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_vld_d = 1'b0;

    if (p_vld_q) begin
      acc_d    = sat_v;
      sat_hi_d = (first ? 1'b0 : sat_hi_q) | hi;
      sat_lo_d = (first ? 1'b0 : sat_lo_q) | lo;
      if (LEN > 0) begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d     = '0;
          res_d     = acc_d;
          res_hi_d  = sat_hi_d;
          res_lo_d  = sat_lo_d;
          res_vld_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      p_vld_q   <= 1'b0;
      acc_q     <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_hi_q  <= 1'b0;
      res_lo_q  <= 1'b0;
      res_vld_q <= 1'b0;
    end else if (!clr_n) begin
      // results of completed frames survive a clear
      p_vld_q   <= 1'b0;
      acc_q     <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      cnt_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_vld_q   <= p_vld_d;
      acc_q     <= acc_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign acc        = acc_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;
  assign res        = res_q;
  assign res_vld    = res_vld_q;
  assign res_sat_hi = res_hi_q;
  assign res_sat_lo = res_lo_q;

endmodule

// File: tb/tb_mac_dot_sat.sv
// Directed bench for mac_dot_sat: four instances cover the saturation, multi-lane and free-running variants.
module tb_mac_dot_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr_n, in_vld;
  logic signed [7:0] a0, a1, b0, b1;

  logic signed [15:0] acc1, res1, acc2, res2;
  logic signed [25:0] acc3, res3, acc4, res4;
  logic sh1, sl1, rv1, rsh1, rsl1;
  logic sh2, sl2, rv2, rsh2, rsl2;
  logic sh3, sl3, rv3, rsh3, rsl3;
  logic sh4, sl4, rv4, rsh4, rsl4;

  mac_dot_sat #(.A_W(8), .B_W(8), .LANES(1), .ACC_W(16), .LEN(3)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a(a0), .b(b0),
    .acc(acc1), .sat_hi(sh1), .sat_lo(sl1), .res(res1), .res_vld(rv1),
    .res_sat_hi(rsh1), .res_sat_lo(rsl1));

  mac_dot_sat #(.A_W(8), .B_W(8), .LANES(1), .ACC_W(16), .LEN(4)) u2 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a(a0), .b(b0),
    .acc(acc2), .sat_hi(sh2), .sat_lo(sl2), .res(res2), .res_vld(rv2),
    .res_sat_hi(rsh2), .res_sat_lo(rsl2));

  mac_dot_sat #(.A_W(8), .B_W(8), .LANES(2), .ACC_W(26), .LEN(2)) u3 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a({a1, a0}), .b({b1, b0}),
    .acc(acc3), .sat_hi(sh3), .sat_lo(sl3), .res(res3), .res_vld(rv3),
    .res_sat_hi(rsh3), .res_sat_lo(rsl3));

  mac_dot_sat #(.A_W(8), .B_W(8), .LANES(1), .ACC_W(26), .LEN(0)) u4 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a(a0), .b(b0),
    .acc(acc4), .sat_hi(sh4), .sat_lo(sl4), .res(res4), .res_vld(rv4),
    .res_sat_hi(rsh4), .res_sat_lo(rsl4));

  int rv4_cnt = 0;
  always @(posedge clk) if (rv4 === 1'b1) rv4_cnt <= rv4_cnt + 1;

  // observation mux: sel picks the instance under test
  int sel = 1;
  logic signed [63:0] o_acc, o_res;
  logic o_rv, o_sh, o_sl, o_rsh, o_rsl;
  always_comb begin
    case (sel)
      2: begin o_acc = 64'(acc2); o_res = 64'(res2); o_rv = rv2; o_sh = sh2; o_sl = sl2; o_rsh = rsh2; o_rsl = rsl2; end
      3: begin o_acc = 64'(acc3); o_res = 64'(res3); o_rv = rv3; o_sh = sh3; o_sl = sl3; o_rsh = rsh3; o_rsl = rsl3; end
      default: begin o_acc = 64'(acc1); o_res = 64'(res1); o_rv = rv1; o_sh = sh1; o_sl = sl1; o_rsh = rsh1; o_rsl = rsl1; end
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int qa0[$], qa1[$], qb0[$], qb1[$], qe[$];
  bit qv[$], qh[$], ql[$];

  task automatic push(input int x0, input int x1, input int y0, input int y1,
                      input int e, input bit v, input bit h, input bit l);
    qa0.push_back(x0); qa1.push_back(x1); qb0.push_back(y0); qb1.push_back(y1);
    qe.push_back(e); qv.push_back(v); qh.push_back(h); ql.push_back(l);
  endtask

  // back-to-back samples; after edge j+1 the acc of sample j-1 is visible
  task automatic run(input string tag);
    int n;
    n = qe.size();
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        in_vld = 1'b1;
        a0 = 8'(qa0[j]); a1 = 8'(qa1[j]); b0 = 8'(qb0[j]); b1 = 8'(qb1[j]);
      end else begin
        in_vld = 1'b0;
      end
      tick();
      if (j >= 1) begin
        chk($sformatf("%s acc[%0d]", tag, j-1), o_acc, 64'(qe[j-1]));
        chk($sformatf("%s res_vld[%0d]", tag, j-1), 64'(o_rv), 64'(qv[j-1]));
        chk($sformatf("%s sat_hi[%0d]", tag, j-1), 64'(o_sh), 64'(qh[j-1]));
        chk($sformatf("%s sat_lo[%0d]", tag, j-1), 64'(o_sl), 64'(ql[j-1]));
      end
    end
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
    qe.delete(); qv.delete(); qh.delete(); ql.delete();
  endtask

  task automatic clr();
    in_vld = 1'b0;
    clr_n  = 1'b0;
    tick();
    clr_n  = 1'b1;
  endtask

  initial begin
    int acc_cnt, pulses;
    longint part;
    longint expq[$];

    rst_n = 1'b0; clr_n = 1'b1; in_vld = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    tick(); tick();
    chk("reset acc", o_acc, 0);
    chk("reset res", o_res, 0);
    chk("reset res_vld", 64'(o_rv), 0);
    chk("reset sat_hi", 64'(o_sh), 0);
    chk("reset res_sat_lo", 64'(o_rsl), 0);
    rst_n = 1'b1;
    tick();

    // basic frame, LEN=3
    sel = 1;
    push(2, 0, 5, 0, 10, 0, 0, 0);
    push(-2, 0, 5, 0, 0, 0, 0, 0);
    push(-3, 0, 8, 0, -24, 1, 0, 0);
    run("t1");
    tick();
    chk("t1 res_vld one cycle", 64'(o_rv), 0);
    chk("t1 res", o_res, -24);
    chk("t1 res bits", 64'(res1[15:0]), 64'h0000_0000_0000_FFE8);
    chk("t1 res_sat_hi", 64'(o_rsh), 0);
    chk("t1 res_sat_lo", 64'(o_rsl), 0);

    // positive saturation
    clr();
    push(126, 0, 126, 0, 15876, 0, 0, 0);
    push(126, 0, 126, 0, 31752, 0, 0, 0);
    push(126, 0, 126, 0, 32767, 1, 1, 0);
    run("t2");
    chk("t2 res", o_res, 32767);
    chk("t2 res_sat_hi", 64'(o_rsh), 1);
    chk("t2 res_sat_lo", 64'(o_rsl), 0);

    // mid-frame clear with a sample presented in the clear cycle
    clr();
    push(-128, 0, -128, 0, 16384, 0, 0, 0);
    push(-128, 0, -128, 0, 32767, 0, 1, 0);
    run("t5pre");
    in_vld = 1'b1; a0 = 8'sd3; b0 = 8'sd3; clr_n = 1'b0;
    tick();
    chk("t5 clr acc", o_acc, 0);
    chk("t5 clr sat_hi", 64'(o_sh), 0);
    chk("t5 clr res_vld", 64'(o_rv), 0);
    chk("t5 clr res kept", o_res, 32767);
    chk("t5 clr res_sat_hi kept", 64'(o_rsh), 1);
    clr_n = 1'b1; in_vld = 1'b0;
    tick(); tick();
    chk("t5 dropped sample acc", o_acc, 0);
    chk("t5 dropped sample res_vld", 64'(o_rv), 0);
    push(1, 0, 2, 0, 2, 0, 0, 0);
    push(3, 0, 4, 0, 14, 0, 0, 0);
    push(5, 0, 6, 0, 44, 1, 0, 0);
    run("t5");
    chk("t5 res", o_res, 44);
    chk("t5 res_sat_hi", 64'(o_rsh), 0);

    // negative saturation then recovery off the rail, LEN=4
    clr();
    sel = 2;
    push(126, 0, -126, 0, -15876, 0, 0, 0);
    push(126, 0, -126, 0, -31752, 0, 0, 0);
    push(126, 0, -126, 0, -32768, 0, 0, 1);
    push(126, 0, 126, 0, -16892, 1, 0, 1);
    run("t3");
    chk("t3 res", o_res, -16892);
    chk("t3 res_sat_lo", 64'(o_rsl), 1);
    chk("t3 res_sat_hi", 64'(o_rsh), 0);

    // two lanes, LEN=2; third sample starts a new frame from zero
    clr();
    sel = 3;
    push(3, -4, 5, 6, -9, 0, 0, 0);
    push(1, 1, 7, 7, 5, 1, 0, 0);
    push(2, -3, 10, 4, 8, 0, 0, 0);
    run("t4");
    chk("t4 res", o_res, 5);

    // random stream with gaps against a dot-product model
    clr();
    acc_cnt = 0; pulses = 0; part = 0;
    for (int c = 0; c < 80 + 3; c++) begin
      if (c < 80) begin
        in_vld = ($urandom_range(0, 2) != 0);
        a0 = 8'($urandom_range(0, 255)); a1 = 8'($urandom_range(0, 255));
        b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
        if (in_vld) begin
          part += longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
          acc_cnt++;
          if (acc_cnt % 2 == 0) begin
            expq.push_back(part);
            part = 0;
          end
        end
      end else begin
        in_vld = 1'b0;
      end
      tick();
      if (o_rv === 1'b1) begin
        pulses++;
        if (expq.size() > 0) chk($sformatf("stream res #%0d", pulses), o_res, expq.pop_front());
      end
    end
    chk("stream res_vld count", 64'(pulses), 64'(acc_cnt / 2));

    // reset mid-frame zeroes everything, including res
    sel = 1;
    in_vld = 1'b1; a0 = 8'sd126; b0 = 8'sd126;
    tick();
    in_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst acc", o_acc, 0);
    chk("rst res", o_res, 0);
    chk("rst res_vld", 64'(o_rv), 0);
    chk("rst sat_hi", 64'(o_sh), 0);
    chk("rst res_sat_hi", 64'(o_rsh), 0);
    chk("rst u3 res", 64'(res3), 0);
    rst_n = 1'b1;
    tick();

    chk("len0 never res_vld", 64'(rv4_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_dot_sat.md
# mac_dot_sat

Parametrised successor to the single-lane `mac`. It is a pipelined, multi-lane signed multiply-accumulate engine with saturating accumulation and sticky overflow/underflow flags. It computes fixed-length dot products, emits one result per frame, and restarts the next frame with no bubble. It sits in the datapath wherever a filter tap or feature sum needs more lanes, a configurable accumulator width, or explicit overflow reporting.

## Interface
- `A_W`, 8, signed width of each `a` lane element
- `B_W`, 8, signed width of each `b` lane element
- `LANES`, 1, number of parallel products summed per accepted sample (≥1)
- `ACC_W`, 26, signed accumulator/result width; must be ≥ A_W+B_W+$clog2(LANES)
- `LEN`, 4, accepted samples per frame; 0 = free-running (never emits `res_vld`)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `clr_n`  in  1  synchronous active-low clear of the accumulation state
- `in_vld`  in  1  `a`/`b` hold a valid sample this cycle
- `a`  in  LANES*A_W  packed signed operands; lane i = a[i*A_W +: A_W]
- `b`  in  LANES*B_W  packed signed operands, same packing
- `acc`  out  ACC_W  running saturated accumulator
- `sat_hi`  out  1  sticky: running accumulator clipped at max in the current frame
- `sat_lo`  out  1  sticky: running accumulator clipped at min in the current frame
- `res`  out  ACC_W  final accumulator value of the last completed frame
- `res_vld`  out  1  one-cycle pulse: `res`/`res_sat_hi`/`res_sat_lo` updated
- `res_sat_hi`, `res_sat_lo`  out  1 each  sticky flags captured with `res`

## Operation
- Stage 1 (product): when `in_vld`=1, form P = Σ a_i·b_i over all lanes. Each product is a full signed A_W+B_W product; the sum is carried at A_W+B_W+$clog2(LANES) bits, which never overflows. Register P with `p_vld`.
- Stage 2 (accumulate): when `p_vld`=1, compute S = base + sext(P) at ACC_W+1 bits. `base` = 0 on the first term of a frame, otherwise `acc`.
  - If S > 2^(ACC_W-1)-1: `acc` = max and `sat_hi` is set.
  - If S < -2^(ACC_W-1): `acc` = min and `sat_lo` is set.
  - Otherwise `acc` = S.
- Clipping is per step, not sticky in value: a later opposite-sign term moves `acc` off the rail. The flags stay set until the frame ends or a clear occurs.
- Term counter (0..LEN-1) advances on each accumulation.
  - On the LEN-th term: `res` ← new acc value, `res_sat_*` ← new flag values, `res_vld` pulses, counter wraps to 0.
  - The next term then uses base=0, and `sat_hi`/`sat_lo` re-initialise to that term's saturation result.
  - `acc` keeps showing the final frame value until the next term arrives.
- Back-to-back frames with `in_vld` held high need no idle cycle. Gaps in `in_vld` are allowed anywhere and do not advance the counter.
- `clr_n`=0:
  - Zeroes `acc`, `sat_hi`, `sat_lo`, the term counter and `p_vld`.
  - Drops any sample presented in that cycle and any product in flight.
  - `res`/`res_sat_*` are retained; `res_vld` is 0.
- `rst_n`=0 has priority over `clr_n`. It zeroes all state and all outputs.
- Frame-end and new-term events can coincide with a clear; clear wins and no `res_vld` is emitted.

## Timing
- Reset values: `acc`=0, `sat_hi`=0, `sat_lo`=0, `res`=0, `res_vld`=0, `res_sat_hi`=0, `res_sat_lo`=0.
- A sample presented with `in_vld` in cycle n is sampled at edge n. P is registered at edge n. `acc`/flags update at edge n+1, so the result is visible in cycle n+2.
- `res_vld` asserts in the same cycle the LEN-th term's `acc` becomes visible, i.e. 2 cycles after that sample is presented.
- Throughput: one sample per cycle, sustained indefinitely.
- `clr_n`/`rst_n` low at edge k: all cleared state reads 0 from cycle k+1. The first sample accepted after the clear is the one presented when `clr_n`=1.

## Test plan
- LANES=1, ACC_W=16, LEN=3; samples (2,5),(−2,5),(−3,8) back-to-back -> `acc` sequence 10, 0, −24; `res`=−24 (0xFFE8) with a one-cycle `res_vld`; flags 0.
- ACC_W=16, LEN=3, three samples (126,126) -> `acc` 15876, 31752, 32767; `sat_hi`=1 from the 3rd step; `res`=32767, `res_sat_hi`=1.
- ACC_W=16, LEN=4, samples (126,−126)×3 then (126,126) -> `acc` −15876, −31752, −32768, −16892; `sat_lo` stays 1; `res`=−16892, `res_sat_lo`=1.
- LANES=2, LEN=2, {a}={3,−4}, {b}={5,6}, then {1,1},{7,7} -> terms −9 and 14; `res`=5; a third sample with base 0 gives `acc`=that term only.
- `clr_n` pulsed low for one cycle after the 2nd of 3 terms, with `in_vld`=1 in that cycle -> `acc`=0, flags 0, that sample dropped, no `res_vld`. The following 3 samples form a complete frame. `rst_n` low mid-frame zeroes every output, including `res`.
- LEN=2 continuous stream with random `in_vld` gaps -> `res_vld` exactly once per 2 accepted samples; each `res` equals a model dot product; LEN=0 never asserts `res_vld`.
